// File: rtl/adder_accumulator_seq.sv
// adder_accumulator_seq
// Sequencer/accumulator wrapped around an external structural ripple adder.
// Operands arrive over a valid/ready handshake, are presented to the adder
// together with the running accumulator, and the adder outputs are captured
// after a programmable settle time. Each result is offered downstream over a
// second valid/ready handshake. A sticky overflow flag ORs every captured
// overflow since the last clear.

module adder_accumulator_seq #(
    parameter int unsigned WIDTH         = 4,
    // Edges the adder inputs are held before its outputs are sampled; >= 1.
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    // Operand input
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_operand,
    input  logic             in_clear,
    // To / from the external adder
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    input  logic [WIDTH-1:0] adder_sum,
    input  logic             adder_carryout,
    input  logic             adder_overflow,
    // Result output
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carryout,
    output logic             out_overflow,
    output logic             sticky_overflow
);

    localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHold
    } state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    // The accumulator doubles as the presented sum: a captured result is the
    // new accumulator by definition.
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] adder_a_q;
    logic [WIDTH-1:0] adder_b_q;
    logic             carry_q;
    logic             ovf_q;
    logic             sticky_q;

    // Sequencer: accept operand, hold adder inputs for the settle time,
    // capture the adder outputs, then hold the result until it is consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            adder_a_q <= '0;
            adder_b_q <= '0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        // A clear restarts the running sum from zero.
                        adder_a_q <= in_clear ? '0 : acc_q;
                        adder_b_q <= in_operand;
                        if (in_clear) begin
                            sticky_q <= 1'b0;
                        end
                        cnt_q   <= CntInit;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        // Flags come straight from the adder; never recomputed here.
                        acc_q    <= adder_sum;
                        carry_q  <= adder_carryout;
                        ovf_q    <= adder_overflow;
                        sticky_q <= sticky_q | adder_overflow;
                        state_q  <= StHold;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Handshake flags decode directly from the state register.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StHold);
    end

    // Output drive from the holding registers.
    always_comb begin
        adder_a         = adder_a_q;
        adder_b         = adder_b_q;
        out_sum         = acc_q;
        out_carryout    = carry_q;
        out_overflow    = ovf_q;
        sticky_overflow = sticky_q;
    end

endmodule

// File: tb/tb_adder_accumulator_seq.sv
// Testbench for adder_accumulator_seq: stands in for the external 4-bit adder,
// runs a directed vector table, stall / reset / long-settle sequences, and a
// randomized run against an arithmetic reference model.

module tb_adder_accumulator_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_clear, out_ready;
    logic [3:0] in_operand;

    // SETTLE_CYCLES = 1 instance
    logic       in_ready, out_valid, out_co, out_ov, sticky;
    logic [3:0] adder_a, adder_b, adder_sum, out_sum;
    logic       adder_co, adder_ov;

    // SETTLE_CYCLES = 3 instance
    logic       in_valid3, out_ready3;
    logic       in_ready3, out_valid3, out_co3, out_ov3, sticky3;
    logic [3:0] adder_a3, adder_b3, adder_sum3, out_sum3;
    logic       adder_co3, adder_ov3;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_acc;
    bit m_sticky;

    always #5 clk = ~clk;

    // Behavioural stand-ins for the structural adder.
    assign {adder_co, adder_sum}   = {1'b0, adder_a} + {1'b0, adder_b};
    assign adder_ov  = (adder_a[3] == adder_b[3]) && (adder_sum[3] != adder_a[3]);
    assign {adder_co3, adder_sum3} = {1'b0, adder_a3} + {1'b0, adder_b3};
    assign adder_ov3 = (adder_a3[3] == adder_b3[3]) && (adder_sum3[3] != adder_a3[3]);

    adder_accumulator_seq #(.WIDTH(4), .SETTLE_CYCLES(1)) u_dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_operand      (in_operand),
        .in_clear        (in_clear),
        .adder_a         (adder_a),
        .adder_b         (adder_b),
        .adder_sum       (adder_sum),
        .adder_carryout  (adder_co),
        .adder_overflow  (adder_ov),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sum         (out_sum),
        .out_carryout    (out_co),
        .out_overflow    (out_ov),
        .sticky_overflow (sticky)
    );

    adder_accumulator_seq #(.WIDTH(4), .SETTLE_CYCLES(3)) u_dut3 (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid3),
        .in_ready        (in_ready3),
        .in_operand      (in_operand),
        .in_clear        (in_clear),
        .adder_a         (adder_a3),
        .adder_b         (adder_b3),
        .adder_sum       (adder_sum3),
        .adder_carryout  (adder_co3),
        .adder_overflow  (adder_ov3),
        .out_valid       (out_valid3),
        .out_ready       (out_ready3),
        .out_sum         (out_sum3),
        .out_carryout    (out_co3),
        .out_overflow    (out_ov3),
        .sticky_overflow (sticky3)
    );

    typedef struct {
        bit         clr;
        logic [3:0] op;
        logic [3:0] ea;
        logic [3:0] es;
        bit         eco;
        bit         eov;
        bit         est;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: signed wrap-around accumulate from plain integer arithmetic.
    task automatic model_step(input bit clr, input logic [3:0] op,
                              output logic [3:0] ea, output logic [3:0] es,
                              output bit eco, output bit eov, output bit est);
        int a_u, s_u, a_s, o_s, s_s;
        a_u = clr ? 0 : m_acc;
        s_u = a_u + int'(op);
        a_s = (a_u >= 8) ? a_u - 16 : a_u;
        o_s = (int'(op) >= 8) ? int'(op) - 16 : int'(op);
        s_s = a_s + o_s;
        ea  = 4'(a_u);
        es  = 4'(s_u % 16);
        eco = (s_u > 15);
        eov = (s_s > 7) || (s_s < -8);
        if (clr) m_sticky = 1'b0;
        m_sticky = m_sticky | eov;
        est   = m_sticky;
        m_acc = s_u % 16;
    endtask

    // One transaction on the SETTLE_CYCLES=1 instance. During the rdly stall
    // cycles in_valid is pulsed with junk that must be ignored.
    task automatic run_txn(input string tag, input bit clr, input logic [3:0] op,
                           input int rdly, input logic [3:0] ea, input logic [3:0] es,
                           input bit eco, input bit eov, input bit est);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " in_ready"}, in_ready, 1);
        in_valid = 1'b1; in_clear = clr; in_operand = op;
        @(posedge clk); #1;
        in_valid = 1'b0; in_clear = 1'b0; in_operand = 4'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " latency"}, n, 1);
        check({tag, " adder_a"}, adder_a, ea);
        check({tag, " adder_b"}, adder_b, op);
        check({tag, " sum"}, out_sum, es);
        check({tag, " carryout"}, out_co, eco);
        check({tag, " overflow"}, out_ov, eov);
        check({tag, " sticky"}, sticky, est);
        for (int k = 0; k < rdly; k++) begin
            in_valid = 1'b1; in_clear = 1'($urandom); in_operand = 4'($urandom);
            @(posedge clk); #1;
            check({tag, " stall out_valid"}, out_valid, 1);
            check({tag, " stall in_ready"}, in_ready, 0);
            check({tag, " stall sum"}, out_sum, es);
            check({tag, " stall flags"}, {out_co, out_ov, sticky}, {eco, eov, est});
            check({tag, " stall adder_ab"}, {adder_a, adder_b}, {ea, op});
        end
        in_valid = 1'b0; in_clear = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " consumed"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic [3:0] ea, es;
        bit eco, eov, est;

        tbl[0] = '{clr: 1, op: 4'b0100, ea: 4'b0000, es: 4'b0100, eco: 0, eov: 0, est: 0};
        tbl[1] = '{clr: 0, op: 4'b1110, ea: 4'b0100, es: 4'b0010, eco: 1, eov: 0, est: 0};
        tbl[2] = '{clr: 1, op: 4'b0110, ea: 4'b0000, es: 4'b0110, eco: 0, eov: 0, est: 0};
        tbl[3] = '{clr: 0, op: 4'b0110, ea: 4'b0110, es: 4'b1100, eco: 0, eov: 1, est: 1};
        tbl[4] = '{clr: 0, op: 4'b0011, ea: 4'b1100, es: 4'b1111, eco: 0, eov: 0, est: 1};

        reset = 1'b1; in_valid = 1'b0; in_clear = 1'b0; in_operand = 4'h0;
        out_ready = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0;
        m_acc = 0; m_sticky = 1'b0;

        // Reset state
        #12;
        check("reset in_ready/out_valid", {in_ready, out_valid}, 2'b10);
        check("reset outputs", {out_sum, out_co, out_ov, sticky}, 7'b0);
        check("reset adder_ab", {adder_a, adder_b}, 8'h00);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 5; i++) begin
            model_step(tbl[i].clr, tbl[i].op, ea, es, eco, eov, est);
            run_txn($sformatf("vec%0d", i), tbl[i].clr, tbl[i].op, 0,
                    tbl[i].ea, tbl[i].es, tbl[i].eco, tbl[i].eov, tbl[i].est);
        end

        // Long stall with in_valid pulsing; next result proves nothing was taken
        model_step(1'b0, 4'b0010, ea, es, eco, eov, est);
        run_txn("stall", 1'b0, 4'b0010, 5, ea, es, eco, eov, est);
        model_step(1'b0, 4'b0011, ea, es, eco, eov, est);
        run_txn("after_stall", 1'b0, 4'b0011, 0, ea, es, eco, eov, est);

        // Reset during WAIT (sticky is 1, accumulator non-zero beforehand)
        in_valid = 1'b1; in_clear = 1'b0; in_operand = 4'b0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rstwait in_wait", {in_ready, out_valid}, 2'b00);
        #1 reset = 1'b1;
        #1;
        check("rstwait outputs", {out_sum, out_co, out_ov, sticky}, 7'b0);
        check("rstwait adder_ab", {adder_a, adder_b}, 8'h00);
        check("rstwait in_ready", in_ready, 1);
        @(posedge clk); #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("rstwait no out_valid", out_valid, 0);
        end
        m_acc = 0; m_sticky = 1'b0;

        // SETTLE_CYCLES = 3: exact latency and held adder inputs
        in_valid3 = 1'b1; in_clear = 1'b1; in_operand = 4'b0101;
        @(posedge clk); #1;
        in_valid3 = 1'b0; in_clear = 1'b0; in_operand = 4'b1010;
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("s3a edge%0d adder_ab", k - 1), {adder_a3, adder_b3}, 8'h05);
            @(posedge clk); #1;
            check($sformatf("s3a edge%0d out_valid", k), out_valid3, (k == 3) ? 1 : 0);
        end
        check("s3a result", {out_sum3, out_co3, out_ov3, sticky3}, {4'b0101, 3'b000});
        out_ready3 = 1'b1; @(posedge clk); #1; out_ready3 = 1'b0;
        check("s3a consumed", {out_valid3, in_ready3}, 2'b01);
        in_valid3 = 1'b1; in_clear = 1'b0; in_operand = 4'b0011;
        @(posedge clk); #1;
        in_valid3 = 1'b0; in_operand = 4'b0000;
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("s3b edge%0d adder_ab", k - 1), {adder_a3, adder_b3}, 8'h53);
            @(posedge clk); #1;
            check($sformatf("s3b edge%0d out_valid", k), out_valid3, (k == 3) ? 1 : 0);
        end
        check("s3b result", {out_sum3, out_co3, out_ov3, sticky3}, {4'b1000, 3'b011});
        out_ready3 = 1'b1; @(posedge clk); #1; out_ready3 = 1'b0;

        // Randomized run against the reference model
        for (int i = 0; i < 40; i++) begin
            bit         clr;
            logic [3:0] op;
            int         rdly;
            clr  = ($urandom_range(0, 5) == 0);
            op   = 4'($urandom);
            rdly = $urandom_range(0, 2);
            model_step(clr, op, ea, es, eco, eov, est);
            run_txn($sformatf("rnd%0d", i), clr, op, rdly, ea, es, eco, eov, est);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
